// File: rtl/riscv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared core types and constants (XLEN, fetch states, NOP).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] C_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] C_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if import riscv_pkg::*; ();

    logic            stall_i;
    logic            flush_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            halt_i;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            if_id_valid_o;
    logic [XLEN-1:0] if_id_instr_o;
    logic [XLEN-1:0] if_id_pc_o;
    logic [XLEN-1:0] if_id_pc4_o;
    logic            halted_o;
    logic [XLEN-1:0] perf_fetch_o;
    logic [XLEN-1:0] perf_stall_o;

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, halt_i, imem_rdata_i,
        output imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
               halted_o, perf_fetch_o, perf_stall_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, halt_i, imem_rdata_i,
        input  imem_addr_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o,
               halted_o, perf_fetch_o, perf_stall_o
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register; bubble beats load, otherwise holds.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg import riscv_pkg::*; #(
    parameter logic [XLEN-1:0] NOP_INSTR = C_NOP_INSTR
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             load,
    input  wire             bubble,
    input  wire  [XLEN-1:0] instr_in,
    input  wire  [XLEN-1:0] pc_in,
    input  wire  [XLEN-1:0] pc4_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_pc4   <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_instr <= instr_in;
            r_pc    <= pc_in;
            r_pc4   <= pc4_in;
        end
    end

    assign valid = r_valid;
    assign instr = r_instr;
    assign pc    = r_pc;
    assign pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC, next-PC mux, BOOT/RUN/HALT FSM, IF/ID.
//               Define FETCH_PERF_CNT_EN to build the saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage import riscv_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC  = C_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = C_NOP_INSTR
) (
    input  wire           clk,
    input  wire           rst,
    fetch_stage_if.master bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_load;
    logic            w_bubble;

    assign w_pc_plus4    = r_pc + XLEN'(4);
    assign w_redirect_pc = {bus.redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
                w_bubble     = 1'b1;
                if (bus.redirect_i) w_pc_next = w_redirect_pc;
            end
            RUN: begin
                if (bus.redirect_i) begin
                    w_pc_next = w_redirect_pc;
                    w_bubble  = 1'b1;
                end else if (bus.halt_i) begin
                    // stop on the halt edge itself: PC frozen, nothing captured
                    w_state_next = HALT;
                    w_bubble     = 1'b1;
                end else if (bus.flush_i) begin
                    w_bubble = 1'b1;
                    if (!bus.stall_i) w_pc_next = w_pc_plus4;
                end else if (!bus.stall_i) begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_plus4;
                end
            end
            HALT: begin
                w_bubble = 1'b1;
                if (bus.redirect_i) begin
                    w_state_next = RUN;
                    w_pc_next    = w_redirect_pc;
                end
            end
            default: begin
                w_state_next = BOOT;
                w_bubble     = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .bubble   (w_bubble),
        .instr_in (bus.imem_rdata_i),
        .pc_in    (r_pc),
        .pc4_in   (w_pc_plus4),
        .valid    (bus.if_id_valid_o),
        .instr    (bus.if_id_instr_o),
        .pc       (bus.if_id_pc_o),
        .pc4      (bus.if_id_pc4_o)
    );

    assign bus.imem_addr_o = r_pc;
    assign bus.halted_o    = (r_state == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] r_perf_fetch;
    logic [XLEN-1:0] r_perf_stall;
    logic            w_stall_cnt;

    assign w_stall_cnt = (r_state == RUN) && bus.stall_i && !bus.redirect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_load && (r_perf_fetch != '1))      r_perf_fetch <= r_perf_fetch + XLEN'(1);
            if (w_stall_cnt && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + XLEN'(1);
        end
    end

    assign bus.perf_fetch_o = r_perf_fetch;
    assign bus.perf_stall_o = r_perf_stall;
`else
    assign bus.perf_fetch_o = '0;
    assign bus.perf_stall_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed-vector scoreboard bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import riscv_pkg::*;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        bit          rst, stall, flush, redir, halt;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] instr, pc, pc4, addr;
        logic        halted;
        logic [31:0] pf, ps;
        int          idx;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t exp2[$];
    vec_t q1[$];
    vec_t q2[$];

    fetch_stage_if bus1();
    fetch_stage_if bus2();

    // instruction memory image: word at address a is a ^ FFC4A303
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hFFC4_A303;
    endfunction

    assign bus1.imem_rdata_i = mem_word(bus1.imem_addr_o);
    assign bus2.imem_rdata_i = mem_word(bus2.imem_addr_o);

    fetch_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input bit r, input bit st, input bit fl, input bit rd,
                                input logic [31:0] rpc, input bit ht, input logic v,
                                input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic [31:0] addr,
                                input logic hl, input logic [31:0] pf, input logic [31:0] ps);
        vec_t t;
        t.rst = r; t.stall = st; t.flush = fl; t.redir = rd; t.rpc = rpc; t.halt = ht;
        t.valid = v; t.instr = ins; t.pc = pc; t.pc4 = pc4; t.addr = addr;
        t.halted = hl; t.pf = pf; t.ps = ps; t.idx = 0;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    // monitor: compare outputs #1 after every edge against queued expectations
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("valid",  e.idx, 32'(bus1.if_id_valid_o), 32'(e.valid));
                chk("instr",  e.idx, bus1.if_id_instr_o, e.instr);
                chk("if_pc",  e.idx, bus1.if_id_pc_o, e.pc);
                chk("if_pc4", e.idx, bus1.if_id_pc4_o, e.pc4);
                chk("imem_addr", e.idx, bus1.imem_addr_o, e.addr);
                chk("halted", e.idx, 32'(bus1.halted_o), 32'(e.halted));
                chk("perf_fetch", e.idx, bus1.perf_fetch_o, PERF_EN ? e.pf : 32'h0);
                chk("perf_stall", e.idx, bus1.perf_stall_o, PERF_EN ? e.ps : 32'h0);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("wrap_valid", e.idx, 32'(bus2.if_id_valid_o), 32'(e.valid));
                chk("wrap_instr", e.idx, bus2.if_id_instr_o, e.instr);
                chk("wrap_pc",    e.idx, bus2.if_id_pc_o, e.pc);
                chk("wrap_pc4",   e.idx, bus2.if_id_pc4_o, e.pc4);
                chk("wrap_addr",  e.idx, bus2.imem_addr_o, e.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus1.stall_i = 1'b0; bus1.flush_i = 1'b0; bus1.redirect_i = 1'b0;
        bus1.redirect_pc_i = 32'h0; bus1.halt_i = 1'b0;
        bus2.stall_i = 1'b0; bus2.flush_i = 1'b0; bus2.redirect_i = 1'b0;
        bus2.redirect_pc_i = 32'h0; bus2.halt_i = 1'b0;

        //             rst st fl rd rpc           ht  v  instr         pc            pc4           addr          hl pf ps
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A303, 32'h0,        32'h4,        32'h4,        0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A307, 32'h4,        32'h8,        32'h8,        0, 2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0,  1, 32'hFFC4A307, 32'h4,        32'h8,        32'h8,        0, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0,  1, 32'hFFC4A307, 32'h4,        32'h8,        32'h8,        0, 2, 2));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,      0,  1, 32'hFFC4A307, 32'h4,        32'h8,        32'h8,        0, 2, 3));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A30B, 32'h8,        32'hC,        32'hC,        0, 3, 3));
        vecs.push_back(mk(0, 1, 0, 1, 32'h103,    0,  0, 32'h00000013, 32'h0,        32'h0,        32'h100,      0, 3, 3));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A203, 32'h100,      32'h104,      32'h104,      0, 4, 3));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h108,      0, 4, 3));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h108,      0, 4, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h20,     0,  0, 32'h00000013, 32'h0,        32'h0,        32'h20,       0, 4, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      1,  0, 32'h00000013, 32'h0,        32'h0,        32'h20,       1, 4, 4));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h20,       1, 4, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h20,       1, 4, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h40,     0,  0, 32'h00000013, 32'h0,        32'h0,        32'h40,       0, 4, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A343, 32'h40,       32'h44,       32'h44,       0, 5, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h104,    1,  0, 32'h00000013, 32'h0,        32'h0,        32'h104,      0, 5, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A207, 32'h104,      32'h108,      32'h108,      0, 6, 4));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0,  0, 32'h00000013, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h200,    0,  0, 32'h00000013, 32'h0,        32'h0,        32'h200,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0,  1, 32'hFFC4A103, 32'h200,      32'h204,      32'h204,      0, 1, 0));

        // second instance boots at FFFF_FFFC with idle controls
        exp2.push_back(mk(1, 0, 0, 0, 32'h0, 0, 0, 32'h00000013, 32'h0,        32'h0, 32'hFFFFFFFC, 0, 0, 0));
        exp2.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h00000013, 32'h0,        32'h0, 32'hFFFFFFFC, 0, 0, 0));
        exp2.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h003B5CFF, 32'hFFFFFFFC, 32'h0, 32'h0,        0, 0, 0));
        exp2.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'hFFC4A303, 32'h0,        32'h4, 32'h4,        0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst                = vecs[i].rst;
            bus1.stall_i       = vecs[i].stall;
            bus1.flush_i       = vecs[i].flush;
            bus1.redirect_i    = vecs[i].redir;
            bus1.redirect_pc_i = vecs[i].rpc;
            bus1.halt_i        = vecs[i].halt;
            vecs[i].idx = i;
            q1.push_back(vecs[i]);
            if (i < exp2.size()) begin
                exp2[i].idx = i;
                q2.push_back(exp2[i]);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
